// File: rtl/aemb2_pkg.sv
`default_nettype none
// ============================================================================
// Package : aemb2_pkg
// Purpose : Shared types and defaults for the AEMB2 fetch sequencer.
//           - fsm_state_e     : fetch sequencer state encoding
//           - IWB_TMO_DEFAULT : default IWB acknowledge timeout in cycles
// Rev     : 1.0  initial release
// ============================================================================
package aemb2_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    RETRY = 2'd3
  } fsm_state_e;

  localparam int IWB_TMO_DEFAULT = 15;

endpackage
`default_nettype wire

// File: rtl/aemb2_fetch_sched.sv
`default_nettype none
// ============================================================================
// Module  : aemb2_fetch_sched
// Purpose : Fetch sequencer for the AEMB2 branch/PC unit. Runs the IWB
//           handshake with an ack timeout and single-cycle retry, arbitrates
//           pipeline advance against the data bus, produces the ena/pha
//           strobes and keeps a one-entry skid buffer for an instruction that
//           arrives while a data access is still stalled.
// Ports   : clk_i      clock, posedge
//           rst_i      asynchronous reset, active low
//           iwb_cyc_o  IWB cycle          iwb_stb_o  IWB strobe
//           iwb_ack_i  IWB acknowledge    iwb_dat_i  IWB read data [31:0]
//           dwb_stb_i  data access pending
//           dwb_ack_i  data access acknowledge
//           ins_dat_o  instruction to PC unit [31:0]
//           ins_ack_o  instruction valid  ena_o      pipeline advance
//           pha_o      thread phase       err_o      IWB timeout pulse
// Rev     : 1.0  initial release
// ============================================================================
module aemb2_fetch_sched
  import aemb2_pkg::*;
#(
  parameter int TXE = 1,
  parameter int TMO = IWB_TMO_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        iwb_cyc_o,
  output logic        iwb_stb_o,
  input  logic        iwb_ack_i,
  input  logic [31:0] iwb_dat_i,
  input  logic        dwb_stb_i,
  input  logic        dwb_ack_i,
  output logic [31:0] ins_dat_o,
  output logic        ins_ack_o,
  output logic        ena_o,
  output logic        pha_o,
  output logic        err_o
);

  localparam int            TW       = $clog2(TMO + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TMO - 1);

  fsm_state_e    state, state_nxt;
  logic [TW-1:0] tmo_cnt, tmo_nxt;
  logic [31:0]   skid;
  logic          skid_full;
  logic          pha;
  logic          dok;
  logic          advance;
  logic          capture;

  // Data side is not holding the pipeline back.
  assign dok = ~dwb_stb_i | dwb_ack_i;

  always_comb begin
    state_nxt = state;
    tmo_nxt   = tmo_cnt;
    iwb_cyc_o = 1'b0;
    iwb_stb_o = 1'b0;
    advance   = 1'b0;
    capture   = 1'b0;
    err_o     = 1'b0;
    ins_dat_o = '0;
    case (state)
      IDLE: state_nxt = FETCH;
      FETCH: begin
        iwb_cyc_o = 1'b1;
        iwb_stb_o = 1'b1;
        if (iwb_ack_i) begin
          // An ack on the timeout cycle still wins: the ack branch is tested first.
          tmo_nxt = '0;
          if (dok) begin
            advance   = 1'b1;
            ins_dat_o = iwb_dat_i;
          end else begin
            capture   = 1'b1;
            state_nxt = HOLD;
          end
        end else if (tmo_cnt == TMO_LAST) begin
          state_nxt = RETRY;
        end else begin
          tmo_nxt = tmo_cnt + TW'(1);
        end
      end
      HOLD: begin
        // Strobe stays low here so the skid entry can never be overwritten.
        if (skid_full && dok) begin
          advance   = 1'b1;
          ins_dat_o = skid;
          state_nxt = FETCH;
        end else if (!skid_full) begin
          state_nxt = FETCH;
        end
      end
      RETRY: begin
        err_o     = 1'b1;
        tmo_nxt   = '0;
        state_nxt = FETCH;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state     <= IDLE;
      tmo_cnt   <= '0;
      skid      <= '0;
      skid_full <= 1'b0;
      pha       <= 1'b0;
    end else begin
      state   <= state_nxt;
      tmo_cnt <= tmo_nxt;
      if (capture) begin
        skid      <= iwb_dat_i;
        skid_full <= 1'b1;
      end else if (advance && state == HOLD) begin
        skid_full <= 1'b0;
      end
      // Thread phase flips once per pipeline advance in interleave mode.
      pha <= (TXE != 0) ? (pha ^ advance) : 1'b1;
    end
  end

  assign ena_o     = advance;
  assign ins_ack_o = advance;
  assign pha_o     = pha;

endmodule
`default_nettype wire
